// File: rtl/key_switch_input_unit_pkg.sv
// Shared IO package for the memory-mapped board peripherals.
// Holds the bus addresses of every IO register the CPU load/store path can
// reach (HEX, LEDR, LEDG, KEY, SW, key-edge), the default board widths for
// the push-buttons and slide switches, and a small address decoder used by
// the key/switch input unit's read and write paths.
package key_switch_input_unit_pkg;

   // Default board widths
   localparam int unsigned NKEYS_DEFAULT = 4;
   localparam int unsigned NSW_DEFAULT   = 10;

   // Output peripherals living alongside the input unit
   localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
   localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
   localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;

   // Input unit registers
   localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
   localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
   localparam logic [31:0] ADDR_KEDGE = 32'hF000_0018;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_KEY,
      SEL_SW,
      SEL_KEDGE
   } regSelT;

   // Full 32-bit compare so aliases of the input registers never respond
   function automatic regSelT decodeAddr(input logic [31:0] addr);
      regSelT sel;
      sel = SEL_NONE;
      if (addr == ADDR_KEY) begin
         sel = SEL_KEY;
      end else if (addr == ADDR_SW) begin
         sel = SEL_SW;
      end else if (addr == ADDR_KEDGE) begin
         sel = SEL_KEDGE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/key_switch_input_unit_if.sv
// CPU data-bus interface seen by the memory-mapped input unit.
//   addr   : load/store data address from the ALU
//   rdEn   : load in progress this cycle
//   wrEn   : store in progress this cycle
//   wrData : store data
//   rdData : read data returned combinationally by the peripheral
// The master modport is the CPU side, the slave modport the peripheral side.
interface key_switch_input_unit_if;
   import key_switch_input_unit_pkg::*;

   logic [31:0] addr;
   logic        rdEn;
   logic        wrEn;
   logic [31:0] wrData;
   logic [31:0] rdData;

   modport master (
      output addr,
      output rdEn,
      output wrEn,
      output wrData,
      input  rdData
   );

   modport slave (
      input  addr,
      input  rdEn,
      input  wrEn,
      input  wrData,
      output rdData
   );

endinterface

// File: rtl/key_switch_input_unit_debounce_bit.sv
// Single-bit synchroniser and debouncer.
//   clk   : system clock
//   reset : asynchronous, active-high
//   d     : raw asynchronous input, already polarity-corrected (1 = active)
//   q     : debounced stable level
//   rise  : one-cycle pulse, high in the cycle before q goes 0->1, so a
//           capture register clocked on the same edge as q sees it together
//           with the level change
// A new level is accepted only after the synchronised sample has differed
// from q for DEBOUNCE consecutive cycles; total latency from a raw edge to q
// is 2 + DEBOUNCE cycles.
module debounce_bit
   import key_switch_input_unit_pkg::*;
#(
   parameter int unsigned CNT_BITS = 16,
   parameter int unsigned DEBOUNCE = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise
);

   localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(DEBOUNCE - 1);

   logic                syncA;
   logic                syncB;
   logic [CNT_BITS-1:0] count;
   logic                differ;
   logic                accept;

   // Two-flop synchroniser bringing the raw board input into the clock domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncA <= 1'b0;
         syncB <= 1'b0;
      end else begin
         syncA <= d;
         syncB <= syncA;
      end
   end

   // The counter only runs while the sample disagrees with the stable level,
   // so any glitch back to q restarts the qualification window from zero
   assign differ = syncB ^ q;
   assign accept = differ && (count == LAST_COUNT);
   assign rise   = accept && syncB;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q     <= 1'b0;
         count <= '0;
      end else if (!differ) begin
         count <= '0;
      end else if (accept) begin
         q     <= syncB;
         count <= '0;
      end else begin
         count <= count + CNT_BITS'(1);
      end
   end

endmodule

// File: rtl/key_switch_input_unit.sv
// Memory-mapped KEY/SW input peripheral on the CPU load path.
//   clk      : system clock (divided CPU clock)
//   reset    : asynchronous, active-high
//   KEY      : raw push-buttons, 0 = pressed
//   SW       : raw slide switches
//   bus      : CPU data bus (slave side); rdData is combinational
//   keyEvent : OR of all sticky press bits
// Registers: ADDR_KEY (debounced key level, 1 = pressed), ADDR_SW (debounced
// switch level), ADDR_KEDGE (sticky press bits, write-1-to-clear).
module key_switch_input_unit
   import key_switch_input_unit_pkg::*;
#(
   parameter int unsigned NKEYS    = NKEYS_DEFAULT,
   parameter int unsigned NSW      = NSW_DEFAULT,
   parameter int unsigned CNT_BITS = 16,
   parameter int unsigned DEBOUNCE = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NKEYS-1:0]         KEY,
   input  logic [NSW-1:0]           SW,
   key_switch_input_unit_if.slave   bus,
   output logic                     keyEvent
);

   logic [NKEYS-1:0] keyLevel;
   logic [NKEYS-1:0] keyRise;
   logic [NSW-1:0]   swLevel;
   logic [NSW-1:0]   unusedSwRise;
   logic [NKEYS-1:0] kedge;
   logic [NKEYS-1:0] clearMask;
   logic             unusedWrData;
   regSelT           readSel;

   // Keys are inverted ahead of the synchroniser so every internal level
   // reads 1 = pressed
   for (genvar i = 0; i < NKEYS; i++) begin : gKey
      debounce_bit #(
         .CNT_BITS (CNT_BITS),
         .DEBOUNCE (DEBOUNCE)
      ) uKeyDebounce (
         .clk   (clk),
         .reset (reset),
         .d     (~KEY[i]),
         .q     (keyLevel[i]),
         .rise  (keyRise[i])
      );
   end

   // Switches share the same debouncer; their rise pulses have no consumer
   for (genvar i = 0; i < NSW; i++) begin : gSw
      debounce_bit #(
         .CNT_BITS (CNT_BITS),
         .DEBOUNCE (DEBOUNCE)
      ) uSwDebounce (
         .clk   (clk),
         .reset (reset),
         .d     (SW[i]),
         .q     (swLevel[i]),
         .rise  (unusedSwRise[i])
      );
   end

   // Only the low NKEYS store bits map onto press bits
   assign unusedWrData = ^bus.wrData[31:NKEYS];

   // Write-1-to-clear mask, only for a store that hits the key-edge register
   always_comb begin
      clearMask = '0;
      if (bus.wrEn && (decodeAddr(bus.addr) == SEL_KEDGE)) begin
         clearMask = bus.wrData[NKEYS-1:0];
      end
   end

   // Sticky press bits: the set term is ORed in after the clear so a press
   // landing in the same cycle as a clear is never lost
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kedge <= '0;
      end else begin
         kedge <= (kedge & ~clearMask) | keyRise;
      end
   end

   assign keyEvent = |kedge;

   // Combinational read mux, zero-extended; reads have no side effects
   always_comb begin
      bus.rdData = 32'd0;
      readSel    = decodeAddr(bus.addr);
      if (bus.rdEn) begin
         case (readSel)
            SEL_KEY:   bus.rdData = 32'(keyLevel);
            SEL_SW:    bus.rdData = 32'(swLevel);
            SEL_KEDGE: bus.rdData = 32'(kedge);
            default:   bus.rdData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_key_switch_input_unit.sv
// Directed self-checking bench for key_switch_input_unit with DEBOUNCE = 4,
// so a raw edge reaches the debounced level 6 clocks later.
module tb_key_switch_input_unit;
   import key_switch_input_unit_pkg::*;

   localparam logic [31:0] ADDR_UNMAPPED = 32'hF000_001C;

   logic       clk;
   logic       reset;
   logic [3:0] keyIn;
   logic [9:0] swIn;
   logic       keyEvent;
   int         checkCount;
   int         failCount;

   key_switch_input_unit_if bus ();

   key_switch_input_unit #(
      .NKEYS    (4),
      .NSW      (10),
      .CNT_BITS (16),
      .DEBOUNCE (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .KEY      (keyIn),
      .SW       (swIn),
      .bus      (bus),
      .keyEvent (keyEvent)
   );

   // 10 ns clock; all driving and sampling happens around the falling edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] key, input logic [9:0] sw);
      keyIn = key;
      swIn  = sw;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic readCheck(input string tag, input logic [31:0] addr,
                            input logic en, input logic [31:0] expected);
      bus.addr = addr;
      bus.rdEn = en;
      #1;
      checkOutput(tag, bus.rdData, expected);
      bus.rdEn = 1'b0;
      bus.addr = 32'd0;
   endtask

   task automatic keyEventCheck(input string tag, input logic expected);
      checkOutput(tag, {31'd0, keyEvent}, {31'd0, expected});
   endtask

   // One-cycle store; the write lands on the next rising edge
   task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
      bus.addr   = addr;
      bus.wrData = data;
      bus.wrEn   = 1'b1;
      @(negedge clk);
      bus.wrEn   = 1'b0;
      bus.wrData = 32'd0;
      bus.addr   = 32'd0;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      bus.addr   = 32'd0;
      bus.rdEn   = 1'b0;
      bus.wrEn   = 1'b0;
      bus.wrData = 32'd0;
      reset      = 1'b1;
      applyStimulus(4'hF, 10'h000);

      // Reset state, all addresses
      tick(3);
      readCheck("rstKey", ADDR_KEY, 1'b1, 32'd0);
      readCheck("rstSw", ADDR_SW, 1'b1, 32'd0);
      readCheck("rstKedge", ADDR_KEDGE, 1'b1, 32'd0);
      readCheck("rstUnmapped", ADDR_UNMAPPED, 1'b1, 32'd0);
      keyEventCheck("rstKeyEvent", 1'b0);
      reset = 1'b0;
      tick(8);
      readCheck("idleKey", ADDR_KEY, 1'b1, 32'd0);
      readCheck("idleKedge", ADDR_KEDGE, 1'b1, 32'd0);

      // Press KEY[1]: visible on cycle 6, not 5
      applyStimulus(4'b1101, 10'h000);
      tick(5);
      readCheck("pressKeyAt5", ADDR_KEY, 1'b1, 32'd0);
      readCheck("pressKedgeAt5", ADDR_KEDGE, 1'b1, 32'd0);
      keyEventCheck("pressEventAt5", 1'b0);
      tick(1);
      readCheck("pressKeyAt6", ADDR_KEY, 1'b1, 32'h2);
      readCheck("pressKedgeAt6", ADDR_KEDGE, 1'b1, 32'h2);
      keyEventCheck("pressEventAt6", 1'b1);
      readCheck("pressKeyRdEnLow", ADDR_KEY, 1'b0, 32'd0);

      // KEY[0] bounces every 2 cycles: never accepted
      for (int i = 0; i < 5; i++) begin
         keyIn[0] = 1'b0;
         tick(2);
         readCheck("bounceKeyLow", ADDR_KEY, 1'b1, 32'h2);
         readCheck("bounceKedgeLow", ADDR_KEDGE, 1'b1, 32'h2);
         keyIn[0] = 1'b1;
         tick(2);
         readCheck("bounceKeyHigh", ADDR_KEY, 1'b1, 32'h2);
      end
      tick(8);
      readCheck("bounceKeySettled", ADDR_KEY, 1'b1, 32'h2);
      readCheck("bounceKedgeSettled", ADDR_KEDGE, 1'b1, 32'h2);

      // Build kedge = 4'hA, then clear bit 3
      applyStimulus(4'b0101, 10'h000);
      tick(6);
      readCheck("key3Level", ADDR_KEY, 1'b1, 32'hA);
      readCheck("kedgeA", ADDR_KEDGE, 1'b1, 32'hA);
      storeWord(ADDR_KEDGE, 32'h8);
      readCheck("w1cClear8", ADDR_KEDGE, 1'b1, 32'h2);
      keyEventCheck("w1cEventStill", 1'b1);
      storeWord(ADDR_KEY, 32'hF);
      readCheck("storeKeyIgnored", ADDR_KEDGE, 1'b1, 32'h2);

      // Release KEY[3]: a release never sets a press bit
      applyStimulus(4'b1101, 10'h000);
      tick(8);
      readCheck("releaseKey3Level", ADDR_KEY, 1'b1, 32'h2);
      readCheck("releaseKey3Kedge", ADDR_KEDGE, 1'b1, 32'h2);

      // Re-press KEY[3] with a clear of bit 3 on the very edge it rises
      applyStimulus(4'b0101, 10'h000);
      tick(5);
      readCheck("racePreKedge", ADDR_KEDGE, 1'b1, 32'h2);
      storeWord(ADDR_KEDGE, 32'h8);
      readCheck("raceSetWins", ADDR_KEDGE, 1'b1, 32'hA);

      // Clear everything, then release all keys
      storeWord(ADDR_KEDGE, 32'hFFFF_FFFF);
      readCheck("clearAll", ADDR_KEDGE, 1'b1, 32'd0);
      keyEventCheck("clearAllEvent", 1'b0);
      applyStimulus(4'hF, 10'h000);
      tick(8);
      readCheck("releaseAllKey", ADDR_KEY, 1'b1, 32'd0);
      readCheck("releaseAllKedge", ADDR_KEDGE, 1'b1, 32'd0);

      // Switches
      applyStimulus(4'hF, 10'h2A5);
      tick(5);
      readCheck("swAt5", ADDR_SW, 1'b1, 32'd0);
      tick(1);
      readCheck("swAt6", ADDR_SW, 1'b1, 32'h2A5);
      storeWord(ADDR_SW, 32'd0);
      readCheck("swStoreIgnored", ADDR_SW, 1'b1, 32'h2A5);
      readCheck("unmappedRead", ADDR_UNMAPPED, 1'b1, 32'd0);
      readCheck("swRdEnLow", ADDR_SW, 1'b0, 32'd0);
      readCheck("keyNoSwLeak", ADDR_KEY, 1'b1, 32'd0);

      // Reset 3 cycles into a KEY[2] press; switch stays on throughout
      applyStimulus(4'b1011, 10'h2A5);
      tick(3);
      reset = 1'b1;
      #1;
      readCheck("midRstSw", ADDR_SW, 1'b1, 32'd0);
      readCheck("midRstKedge", ADDR_KEDGE, 1'b1, 32'd0);
      tick(1);
      reset = 1'b0;
      tick(5);
      readCheck("postRstKedgeAt5", ADDR_KEDGE, 1'b1, 32'd0);
      readCheck("postRstSwAt5", ADDR_SW, 1'b1, 32'd0);
      tick(1);
      readCheck("postRstKedgeAt6", ADDR_KEDGE, 1'b1, 32'h4);
      readCheck("postRstKeyAt6", ADDR_KEY, 1'b1, 32'h4);
      readCheck("postRstSwAt6", ADDR_SW, 1'b1, 32'h2A5);
      keyEventCheck("postRstEvent", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
